// File: rtl/vga_fb_reader_if.sv
// Bundle of the scan-out control, framebuffer read port and VGA output
// signals of vga_fb_reader. The reader drives through the master modport;
// the surrounding system (memory, display sink, enable source) uses slave.
interface vga_fb_reader_if;
  logic        enable;
  logic [16:0] fb_addr;
  logic [2:0]  fb_data;
  logic [2:0]  vga_rgb;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        frame_start;

  modport master (
    input  enable,
    input  fb_data,
    output fb_addr,
    output vga_rgb,
    output vga_hsync,
    output vga_vsync,
    output frame_start
  );

  modport slave (
    output enable,
    output fb_data,
    input  fb_addr,
    input  vga_rgb,
    input  vga_hsync,
    input  vga_vsync,
    input  frame_start
  );
endinterface

// File: rtl/vga_fb_reader.sv
// VGA scan-out engine: generates 640x480@60 timing from the 25 MHz pixel
// clock, reads a QVGA framebuffer with 2x2 pixel doubling and drives
// registered colour, sync and frame-start outputs.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | counters parked at (0,0), outputs drain to blank / syncs high
// S_RUN  | scanning; enable is only looked at on the last pixel of a frame
//
// Pipeline: counters (t) -> fb_addr + delayed flags (t+1) -> fb_data from
// memory + flags (t+2) -> vga_rgb / syncs / frame_start (t+3).
// Porch and sync widths are parameters so reduced geometries can be built;
// the defaults give the standard 800x525 raster.
module vga_fb_reader #(
  parameter int H_VISIBLE = 640,
  parameter int V_VISIBLE = 480,
  parameter int FB_WIDTH  = 320,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk_25,
  input  logic       reset,
  vga_fb_reader_if.master bus
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0]  H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0]  H_SYNC_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0]  H_SYNC_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0]  V_SYNC_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  V_SYNC_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [16:0] FB_STEP    = 17'(FB_WIDTH);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_h_cnt;
  logic [9:0]  r_v_cnt;
  logic [9:0]  w_h_nxt;
  logic [9:0]  w_v_nxt;
  logic [16:0] r_line_base;
  logic [16:0] w_line_base_nxt;

  // stage-0 decode of the current counter position
  logic        w_run;
  logic        w_vis0;
  logic        w_hs0;
  logic        w_vs0;
  logic        w_fs0;
  logic [16:0] w_addr0;

  // stage 1: address presented to memory, flags delayed alongside it
  logic [16:0] r_fb_addr;
  logic        r_vis1;
  logic        r_hs1;
  logic        r_vs1;
  logic        r_fs1;

  // stage 2: memory data arrives, flags delayed once more
  logic        r_vis2;
  logic        r_hs2;
  logic        r_vs2;
  logic        r_fs2;

  // stage 3: output registers
  logic [2:0]  r_rgb;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_frame_start;

  // State and counter register.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_line_base <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_h_cnt     <= w_h_nxt;
      r_v_cnt     <= w_v_nxt;
      r_line_base <= w_line_base_nxt;
    end
  end

  // Next state, raster counters and framebuffer line base.
  always_comb begin
    w_state_nxt     = r_state;
    w_h_nxt         = r_h_cnt;
    w_v_nxt         = r_v_cnt;
    w_line_base_nxt = r_line_base;
    case (r_state)
      S_IDLE: begin
        w_h_nxt         = '0;
        w_v_nxt         = '0;
        w_line_base_nxt = '0;
        if (bus.enable) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (r_h_cnt == H_LAST) begin
          w_h_nxt = '0;
          if (r_v_cnt == V_LAST) begin
            // frame boundary: the only point where enable is honoured
            w_v_nxt         = '0;
            w_line_base_nxt = '0;
            if (!bus.enable) begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_v_nxt = r_v_cnt + 10'd1;
            // each framebuffer row covers two display lines
            if ((r_v_cnt < V_VIS) && r_v_cnt[0]) begin
              w_line_base_nxt = r_line_base + FB_STEP;
            end
          end
        end else begin
          w_h_nxt = r_h_cnt + 10'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Decode visibility, sync windows, frame origin and read address.
  always_comb begin
    w_run   = (r_state == S_RUN);
    w_vis0  = w_run && (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_hs0   = !(w_run && (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END));
    w_vs0   = !(w_run && (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END));
    w_fs0   = w_run && (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);
    w_addr0 = '0;
    if (w_vis0) begin
      w_addr0 = r_line_base + {8'd0, r_h_cnt[9:1]};
    end
  end

  // Stage 1: register the read address and the flags that travel with it.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      r_fb_addr <= '0;
      r_vis1    <= 1'b0;
      r_hs1     <= 1'b1;
      r_vs1     <= 1'b1;
      r_fs1     <= 1'b0;
    end else begin
      r_fb_addr <= w_addr0;
      r_vis1    <= w_vis0;
      r_hs1     <= w_hs0;
      r_vs1     <= w_vs0;
      r_fs1     <= w_fs0;
    end
  end

  // Stage 2: hold the flags while the memory returns data.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      r_vis2 <= 1'b0;
      r_hs2  <= 1'b1;
      r_vs2  <= 1'b1;
      r_fs2  <= 1'b0;
    end else begin
      r_vis2 <= r_vis1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      r_fs2  <= r_fs1;
    end
  end

  // Stage 3: output registers; colour is forced black while blanking.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      r_rgb         <= '0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_rgb         <= r_vis2 ? bus.fb_data : 3'b000;
      r_hsync       <= r_hs2;
      r_vsync       <= r_vs2;
      r_frame_start <= r_fs2;
    end
  end

  assign bus.fb_addr     = r_fb_addr;
  assign bus.vga_rgb     = r_rgb;
  assign bus.vga_hsync   = r_hsync;
  assign bus.vga_vsync   = r_vsync;
  assign bus.frame_start = r_frame_start;

endmodule

// File: doc/vga_fb_reader.md
VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-003 Parameter FB_WIDTH, 320, framebuffer pixels per line (QVGA).
REQ-004 Port clk_25  input  1  25 MHz pixel clock; the block's only clock.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port enable  input  1  request to scan out frames.
REQ-007 Port fb_addr  output  17  framebuffer read address, registered.
REQ-008 Port fb_data  input  3  framebuffer read data, valid one clk_25 after fb_addr.
REQ-009 Port vga_rgb  output  3  pixel colour {r,g,b}, registered.
REQ-010 Port vga_hsync  output  1  horizontal sync, active-low, registered.
REQ-011 Port vga_vsync  output  1  vertical sync, active-low, registered.
REQ-012 Port frame_start  output  1  one-cycle pulse with the first pixel of each frame on the outputs.

Function
REQ-013 Timing SHALL be 640x480@60: h_cnt 0..799 (visible 0-639, front porch 640-655, sync 656-751, back porch 752-799); v_cnt 0..524 (visible 0-479, front porch 480-489, sync 490-491, back porch 492-524).
REQ-014 The state machine SHALL have two states, IDLE and RUN.
REQ-015 In IDLE, h_cnt and v_cnt SHALL hold at 0, vga_hsync/vga_vsync SHALL be 1, vga_rgb and fb_addr SHALL be 0.
REQ-016 IDLE->RUN SHALL occur on the first clock with enable=1; counting SHALL start at (0,0) on the following cycle.
REQ-017 enable SHALL be sampled only at the frame end (h_cnt=799, v_cnt=524): enable=0 goes to IDLE, enable=1 wraps to (0,0); a mid-frame deassertion SHALL NOT truncate the frame.
REQ-018 h_cnt SHALL wrap 799->0 and increment v_cnt; v_cnt SHALL wrap 524->0.
REQ-019 Pixel doubling: visible (h,v) SHALL read framebuffer address (v>>1)*320 + (h>>1), with no multiplier.
REQ-020 A 17-bit line_base register SHALL start at 0 each frame and add 320 after each odd visible line (v=1,3,...,477); fb_addr = line_base + (h>>1).
REQ-021 fb_addr SHALL be 0 outside the visible region; its maximum value SHALL be 76799.
REQ-022 Latency: counter values at cycle t SHALL drive fb_addr at t+1, fb_data SHALL be valid at t+2, and vga_rgb/syncs/frame_start at t+3; syncs and the blank flag SHALL be delayed through matching pipeline stages.
REQ-023 vga_rgb SHALL equal fb_data for visible pixels and 3'b000 during blanking.
REQ-024 vga_hsync SHALL be 0 exactly for h_cnt 656-751 and vga_vsync 0 exactly for v_cnt 490-491, both pipeline-aligned.
REQ-025 frame_start SHALL be 1 for exactly the output cycle carrying pixel (0,0) of each frame, including back-to-back frames.

Reset
REQ-026 Asserting reset SHALL immediately, without a clock edge, force: state IDLE, counters 0, line_base 0, fb_addr 0, vga_rgb 0, vga_hsync 1, vga_vsync 1, frame_start 0, pipeline stages cleared.
REQ-027 After reset deasserts, the block SHALL remain in IDLE until enable=1 per REQ-016.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; the next frame SHALL start at (0,0) with frame_start.

Verification
REQ-029 Reset, enable=1 held -> frame_start pulses every 420000 clocks; vga_hsync low for 96 clocks every 800; vga_vsync low for 1600 clocks per frame.
REQ-030 RAM model returning fb_data = addr[2:0] -> lines 0 and 1 show fb_addr 0,0,1,1,...,319,319; line 2 starts at 320; line 479 ends at 76799; vga_rgb matches 3 cycles after the counters.
REQ-031 fb_data forced to 3'b111 -> vga_rgb = 111 for 640 clocks per visible line and 000 for the other 160 clocks and throughout lines 480-524.
REQ-032 enable dropped at v_cnt=100 -> frame completes to (799,524), then IDLE (syncs 1, rgb 0); enable re-raised -> frame_start appears 4 clocks later.
REQ-033 reset pulsed between clock edges at h_cnt=300 -> outputs take their reset values before the next edge; with enable=1, the first post-reset frame_start follows after 4 clocks.
REQ-034 enable toggled every clock mid-frame -> no change in timing; the frame ends only on the enable value sampled at (799,524).
